gamepad_pmod_driver: RTL and testbench



---
 rtl/gamepad_pmod_driver.sv | 144 ++++++++++++++
 tb/tb_gamepad_pmod_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_driver.sv
// rtl/gamepad_pmod_driver.sv - Gamepad Pmod controller-side emulator.
// Serializes {buttons1,buttons2} MSB first as latch strobe + 24 clocked bits.
module gamepad_pmod_driver #(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8,
  parameter int FRAME_GAP    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons1,
  input  logic [11:0] buttons2,
  input  logic        send_req,
  input  logic        auto_en,
  output logic        busy,
  output logic        frame_done,
  output logic        pmod_latch,
  output logic        pmod_clk,
  output logic        pmod_data
);

  localparam int MAX_A = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int MAX_C = (MAX_A > FRAME_GAP + 1) ? MAX_A : FRAME_GAP + 1;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic [23:0]   shadow, shadow_n;
  logic          busy_n, done_n, latch_n, clk_n, data_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shadow     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pmod_latch <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shadow     <= shadow_n;
      busy       <= busy_n;
      frame_done <= done_n;
      pmod_latch <= latch_n;
      pmod_clk   <= clk_n;
      pmod_data  <= data_n;
    end
  end

  // Outputs are computed for the state being entered so they register together with it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shadow_n  = shadow;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    latch_n   = 1'b0;
    clk_n     = 1'b0;
    data_n    = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        cnt_n  = '0;
        if (send_req || auto_en) begin
          shadow_n  = {buttons1, buttons2};
          bit_idx_n = 5'd23;
          state_n   = LATCH;
          busy_n    = 1'b1;
          latch_n   = 1'b1;
          data_n    = buttons1[11];
        end
      end
      LATCH: begin
        latch_n = 1'b1;
        data_n  = shadow[23];
        if (cnt == CW'(LATCH_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = SHIFT_LO;
          latch_n = 1'b0;
        end
      end
      SHIFT_LO: begin
        data_n = shadow[bit_idx];
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n   = '0;
          state_n = SHIFT_HI;
          clk_n   = 1'b1;
        end
      end
      SHIFT_HI: begin
        clk_n  = 1'b1;
        data_n = shadow[bit_idx];
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n = '0;
          clk_n = 1'b0;
          if (bit_idx != 5'd0) begin
            bit_idx_n = bit_idx - 5'd1;
            state_n   = SHIFT_LO;
            data_n    = shadow[bit_idx - 5'd1];
          end else begin
            data_n = 1'b0;
            done_n = 1'b1;
            if (auto_en) begin
              state_n = GAP;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      end
      GAP: begin
        // First GAP cycle carries frame_done, followed by FRAME_GAP idle cycles.
        if (cnt == CW'(FRAME_GAP)) begin
          cnt_n = '0;
          if (auto_en) begin
            shadow_n  = {buttons1, buttons2};
            bit_idx_n = 5'd23;
            state_n   = LATCH;
            latch_n   = 1'b1;
            data_n    = buttons1[11];
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// tb/tb_gamepad_pmod_driver.sv - Directed self-checking bench for gamepad_pmod_driver.
module tb_gamepad_pmod_driver;
  localparam int CLK_DIV = 2;
  localparam int LATCH_CYCLES = 4;
  localparam int FRAME_GAP = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] buttons1 = '0;
  logic [11:0] buttons2 = '0;
  logic send_req = 1'b0;
  logic auto_en = 1'b0;
  logic busy, frame_done, pmod_latch, pmod_clk, pmod_data;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  gamepad_pmod_driver #(.CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH_CYCLES), .FRAME_GAP(FRAME_GAP)) dut (
    .clk(clk), .reset(reset), .buttons1(buttons1), .buttons2(buttons2),
    .send_req(send_req), .auto_en(auto_en), .busy(busy), .frame_done(frame_done),
    .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic prev_clk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;
  int stable_cnt = 0, rise_count = 0, last_rise = 0;
  int latch_count = 0, done_count = 0, done_time = 0;
  int latch_times [0:7];
  logic [23:0] frame_bits = '0;

  // Protocol monitor: latch width, data stability, bit spacing and bit capture.
  always @(negedge clk) begin
    if (pmod_data !== prev_data) stable_cnt = 0;
    else stable_cnt++;
    if (pmod_latch && !prev_latch) begin
      if (latch_count < 8) latch_times[latch_count] = cyc;
      latch_count++;
      rise_count = 0;
    end
    if (!pmod_latch && prev_latch && latch_count > 0 && latch_count <= 8) begin
      checks++;
      if (cyc - latch_times[latch_count-1] != LATCH_CYCLES) begin
        fails++;
        $display("FAIL latch_width: got %0d want %0d", cyc - latch_times[latch_count-1], LATCH_CYCLES);
      end
    end
    if (pmod_clk && prev_clk) begin
      checks++;
      if (pmod_data !== prev_data) begin
        fails++;
        $display("FAIL data_toggle_while_clk_high: got %b want %b at cycle %0d", pmod_data, prev_data, cyc);
      end
    end
    if (pmod_clk && !prev_clk) begin
      checks++;
      if (stable_cnt < CLK_DIV) begin
        fails++;
        $display("FAIL setup_before_rise: got %0d want >=%0d at cycle %0d", stable_cnt, CLK_DIV, cyc);
      end
      if (rise_count > 0) begin
        checks++;
        if (cyc - last_rise != 2 * CLK_DIV) begin
          fails++;
          $display("FAIL rise_spacing: got %0d want %0d", cyc - last_rise, 2 * CLK_DIV);
        end
      end
      last_rise = cyc;
      rise_count++;
      frame_bits = {frame_bits[22:0], pmod_data};
    end
    if (frame_done === 1'b1) begin
      done_count++;
      done_time = cyc;
    end
    prev_clk = pmod_clk;
    prev_data = pmod_data;
    prev_latch = pmod_latch;
  end

  task automatic clear_mon();
    latch_count = 0;
    done_count = 0;
    rise_count = 0;
    frame_bits = '0;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pmod_latch, pmod_clk, pmod_data, busy, frame_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000", {pmod_latch, pmod_clk, pmod_data, busy, frame_done});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pmod_latch !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b latch=%b want 0 0", busy, pmod_latch);
    end
  endtask

  task automatic test_single_frame();
    buttons1 = 12'hA5C; buttons2 = 12'h3F1;
    clear_mon();
    pulse_req();
    for (int i = 0; i < 300 && done_count < 1; i++) @(negedge clk);
    checks++;
    if (done_count < 1) begin fails++; $display("FAIL single_timeout: got %0d want 1 frame_done", done_count); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_low: got %b want 0", busy); end
    checks++;
    if (frame_bits !== 24'hA5C3F1) begin fails++; $display("FAIL single_bits: got %h want a5c3f1", frame_bits); end
    checks++;
    if (rise_count != 24) begin fails++; $display("FAIL single_rises: got %0d want 24", rise_count); end
    checks++;
    if (done_time - latch_times[0] != 100) begin fails++; $display("FAIL single_done_time: got %0d want 100", done_time - latch_times[0]); end
    checks++;
    if (last_rise - latch_times[0] != 98) begin fails++; $display("FAIL single_last_rise: got %0d want 98", last_rise - latch_times[0]); end
    repeat (10) @(negedge clk);
    checks++;
    if (done_count != 1 || latch_count != 1) begin
      fails++;
      $display("FAIL single_counts: got done=%0d latch=%0d want 1 1", done_count, latch_count);
    end
  endtask

  task automatic test_snapshot();
    buttons1 = 12'h5A3; buttons2 = 12'hC0F;
    clear_mon();
    pulse_req();
    for (int i = 0; i < 300 && rise_count < 10; i++) @(negedge clk);
    buttons1 = 12'hFFF;
    buttons2 = 12'h000;
    for (int i = 0; i < 300 && done_count < 1; i++) @(negedge clk);
    checks++;
    if (done_count < 1) begin fails++; $display("FAIL snapshot_timeout: got %0d want 1 frame_done", done_count); end
    checks++;
    if (frame_bits !== 24'h5A3C0F) begin fails++; $display("FAIL snapshot_bits: got %h want 5a3c0f", frame_bits); end
  endtask

  task automatic test_req_busy();
    buttons1 = 12'h0F0; buttons2 = 12'h00A;
    clear_mon();
    pulse_req();
    repeat (30) @(negedge clk);
    pulse_req();
    for (int i = 0; i < 300 && done_count < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (latch_count != 1 || done_count != 1) begin
      fails++;
      $display("FAIL req_busy_ignored: got latch=%0d done=%0d want 1 1", latch_count, done_count);
    end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL req_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_auto();
    buttons1 = 12'h123; buttons2 = 12'h456;
    clear_mon();
    @(posedge clk); #1 auto_en = 1'b1;
    for (int i = 0; i < 600 && latch_count < 3; i++) @(negedge clk);
    checks++;
    if (latch_count < 3) begin fails++; $display("FAIL auto_timeout: got %0d want 3 latches", latch_count); end
    checks++;
    if (latch_times[1] - latch_times[0] != 121) begin fails++; $display("FAIL auto_period1: got %0d want 121", latch_times[1] - latch_times[0]); end
    checks++;
    if (latch_times[2] - latch_times[1] != 121) begin fails++; $display("FAIL auto_period2: got %0d want 121", latch_times[2] - latch_times[1]); end
    repeat (30) @(negedge clk);
    auto_en = 1'b0;
    for (int i = 0; i < 300 && done_count < 3; i++) @(negedge clk);
    checks++;
    if (done_count != 3) begin fails++; $display("FAIL auto_done_count: got %0d want 3", done_count); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL auto_busy_after_stop: got %b want 0", busy); end
    checks++;
    if (frame_bits !== 24'h123456) begin fails++; $display("FAIL auto_bits: got %h want 123456", frame_bits); end
    repeat (200) @(negedge clk);
    checks++;
    if (latch_count != 3) begin fails++; $display("FAIL auto_no_extra_frame: got %0d want 3", latch_count); end
  endtask

  task automatic test_reset_mid();
    buttons1 = 12'h7C3; buttons2 = 12'h18E;
    clear_mon();
    pulse_req();
    for (int i = 0; i < 300 && rise_count < 12; i++) @(negedge clk);
    checks++;
    if (pmod_clk !== 1'b1 || pmod_data !== 1'b1) begin
      fails++;
      $display("FAIL mid_bit12_state: got clk=%b data=%b want 1 1", pmod_clk, pmod_data);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({pmod_clk, pmod_data, busy, pmod_latch, frame_done} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset: got %b want 00000", {pmod_clk, pmod_data, busy, pmod_latch, frame_done});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_count != 0) begin fails++; $display("FAIL no_done_on_reset: got %0d want 0", done_count); end
    clear_mon();
    pulse_req();
    for (int i = 0; i < 300 && done_count < 1; i++) @(negedge clk);
    checks++;
    if (rise_count != 24 || frame_bits !== 24'h7C318E) begin
      fails++;
      $display("FAIL frame_after_reset: got rises=%0d bits=%h want 24 7c318e", rise_count, frame_bits);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_snapshot();
    test_req_busy();
    test_auto();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
